// File: rtl/conv_event_address_generator.sv
// conv_event_address_generator
// Takes one AER spike event {row, col} and sweeps the K x K filter window for
// each of C_OUT output channels, emitting one beat per in-range tap with the
// weight-ROM address, the Vmem-RAM address and the output-map coordinates.
//
// Ports:
//   work_clk        clock, rising edge
//   rst             synchronous active-high reset
//   aer_event       {row, col} of the incoming event
//   aer_valid/ready event handshake
//   out_valid/ready beat handshake
//   A_weight        weight ROM address (descending tap index per channel)
//   A_Vmem          Vmem RAM address
//   current_M/N     output-map row/col of the beat
//   current_ch      channel of the beat
//   operating_flag  high while a sweep is in progress (OPER and END)
//   done            one-cycle pulse at end of sweep
//   err             one-cycle pulse after an out-of-range event is dropped
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an event, aer_ready=1
// S_OPER | sweeping ch/m/n, beats presented on the outputs
// S_END  | single cycle, done=1, then back to S_IDLE
module conv_event_address_generator #(
  parameter int K       = 5,
  parameter int PAD_W   = 32,
  parameter int PAD_H   = 32,
  parameter int C_OUT   = 2,
  parameter int COORD_W = 8,
  parameter int CH_W    = 1,
  parameter int WA_W    = 6,
  parameter int VA_W    = 11
) (
  input  logic                 work_clk,
  input  logic                 rst,
  input  logic [2*COORD_W-1:0] aer_event,
  input  logic                 aer_valid,
  output logic                 aer_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WA_W-1:0]      A_weight,
  output logic [VA_W-1:0]      A_Vmem,
  output logic [COORD_W-1:0]   current_M,
  output logic [COORD_W-1:0]   current_N,
  output logic [CH_W-1:0]      current_ch,
  output logic                 operating_flag,
  output logic                 done,
  output logic                 err
);

  localparam int IW = 32;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int KK = K * K;

  localparam logic [IW-1:0]   PAD_H_U = IW'(PAD_H);
  localparam logic [IW-1:0]   PAD_W_U = IW'(PAD_W);
  localparam logic [VA_W-1:0] PAD_W_V = VA_W'(PAD_W);
  localparam logic [VA_W-1:0] PLANE_V = VA_W'(PAD_H * PAD_W);

  typedef enum logic [1:0] {S_IDLE, S_OPER, S_END} state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] evt_row, evt_col;
  logic [COORD_W-1:0] row_q, col_q;
  logic [CH_W-1:0]    ch;
  logic [KW-1:0]      m, n;
  logic [WA_W-1:0]    wa;
  logic [VA_W-1:0]    vm_row;   // ch*PAD_H*PAD_W + (row+m)*PAD_W
  logic [VA_W-1:0]    ch_base;  // ch*PAD_H*PAD_W
  logic [VA_W-1:0]    row_pw;   // row*PAD_W, fixed for the whole sweep
  logic [VA_W-1:0]    vm_addr;
  logic [IW-1:0]      m_abs, n_abs;
  logic               err_q;
  logic               accept, evt_oor, in_range, step, last_idx;

  assign evt_row = aer_event[2*COORD_W-1:COORD_W];
  assign evt_col = aer_event[COORD_W-1:0];

  assign accept  = aer_valid && (state == S_IDLE);
  assign evt_oor = (IW'(evt_row) >= PAD_H_U) || (IW'(evt_col) >= PAD_W_U);

  // Wide sums so the range compare never sees a wrapped coordinate.
  assign m_abs    = IW'(row_q) + IW'(m);
  assign n_abs    = IW'(col_q) + IW'(n);
  assign in_range = (m_abs < PAD_H_U) && (n_abs < PAD_W_U);

  // Clipped taps advance on their own; in-range taps wait for the transfer.
  assign step     = (state == S_OPER) && (!in_range || out_ready);
  assign last_idx = (ch == CH_W'(C_OUT - 1)) && (m == KW'(K - 1)) && (n == KW'(K - 1));

  assign vm_addr = vm_row + VA_W'(col_q) + VA_W'(n);
  assign err     = err_q;

  always_ff @(posedge work_clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    aer_ready      = 1'b0;
    out_valid      = 1'b0;
    operating_flag = 1'b0;
    done           = 1'b0;
    A_weight       = '0;
    A_Vmem         = '0;
    current_M      = '0;
    current_N      = '0;
    current_ch     = '0;
    case (state)
      S_IDLE: begin
        aer_ready = 1'b1;
        if (aer_valid && !evt_oor) state_nxt = S_OPER;
      end
      S_OPER: begin
        operating_flag = 1'b1;
        out_valid      = in_range;
        A_weight       = wa;
        A_Vmem         = vm_addr;
        current_M      = row_q + COORD_W'(m);
        current_N      = col_q + COORD_W'(n);
        current_ch     = ch;
        if (step && last_idx) state_nxt = S_END;
      end
      S_END: begin
        operating_flag = 1'b1;
        done           = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address datapath: everything is carried incrementally from the previous
  // beat; the only multiply is row*PAD_W, taken once when the event lands.
  always_ff @(posedge work_clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      ch      <= '0;
      m       <= '0;
      n       <= '0;
      wa      <= '0;
      vm_row  <= '0;
      ch_base <= '0;
      row_pw  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && evt_oor;
      if (accept) begin
        row_q   <= evt_row;
        col_q   <= evt_col;
        ch      <= '0;
        m       <= '0;
        n       <= '0;
        wa      <= WA_W'(KK - 1);
        row_pw  <= VA_W'(IW'(evt_row) * PAD_W_U);
        vm_row  <= VA_W'(IW'(evt_row) * PAD_W_U);
        ch_base <= '0;
      end else if (step && !last_idx) begin
        if (n == KW'(K - 1)) begin
          n <= '0;
          if (m == KW'(K - 1)) begin
            // Channel wrap: jump to the next plane and restart the window.
            m       <= '0;
            ch      <= ch + CH_W'(1);
            ch_base <= ch_base + PLANE_V;
            vm_row  <= ch_base + PLANE_V + row_pw;
            wa      <= wa + WA_W'(2 * KK - 1);
          end else begin
            m      <= m + KW'(1);
            vm_row <= vm_row + PAD_W_V;
            wa     <= wa - WA_W'(1);
          end
        end else begin
          n  <= n + KW'(1);
          wa <= wa - WA_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_event_address_generator.sv
module tb_conv_event_address_generator;

  localparam int K       = 5;
  localparam int PAD_W   = 32;
  localparam int PAD_H   = 32;
  localparam int C_OUT   = 2;
  localparam int COORD_W = 8;
  localparam int CH_W    = 1;
  localparam int WA_W    = 6;
  localparam int VA_W    = 11;

  logic                 work_clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2*COORD_W-1:0] aer_event = '0;
  logic                 aer_valid = 1'b0;
  logic                 aer_ready;
  logic                 out_ready = 1'b1;
  logic                 out_valid;
  logic [WA_W-1:0]      A_weight;
  logic [VA_W-1:0]      A_Vmem;
  logic [COORD_W-1:0]   current_M;
  logic [COORD_W-1:0]   current_N;
  logic [CH_W-1:0]      current_ch;
  logic                 operating_flag;
  logic                 done;
  logic                 err;

  conv_event_address_generator #(
    .K(K), .PAD_W(PAD_W), .PAD_H(PAD_H), .C_OUT(C_OUT), .COORD_W(COORD_W),
    .CH_W(CH_W), .WA_W(WA_W), .VA_W(VA_W)
  ) dut (
    .work_clk(work_clk), .rst(rst), .aer_event(aer_event), .aer_valid(aer_valid),
    .aer_ready(aer_ready), .out_ready(out_ready), .out_valid(out_valid),
    .A_weight(A_weight), .A_Vmem(A_Vmem), .current_M(current_M),
    .current_N(current_N), .current_ch(current_ch),
    .operating_flag(operating_flag), .done(done), .err(err)
  );

  always #5 work_clk = ~work_clk;

  typedef struct packed {
    logic [31:0] wa;
    logic [31:0] va;
    logic [31:0] mm;
    logic [31:0] nn;
    logic [31:0] ch;
  } beat_t;

  beat_t sb[$];
  beat_t seen[$];
  int n_assert = 0;
  int n_fail   = 0;
  int op_cycles, done_cnt, xfers;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge work_clk);
    #1;
  endtask

  task automatic clr();
    op_cycles = 0;
    done_cnt  = 0;
    xfers     = 0;
    seen.delete();
  endtask

  // Reference model: direct formulas, all taps in sweep order, clipped ones dropped.
  task automatic push_event(input int row, input int col);
    beat_t b;
    for (int c = 0; c < C_OUT; c++)
      for (int mi = 0; mi < K; mi++)
        for (int ni = 0; ni < K; ni++)
          if (row + mi < PAD_H && col + ni < PAD_W) begin
            b.wa = 32'(c * K * K + (K * K - 1) - (mi * K + ni));
            b.va = 32'((c * PAD_H * PAD_W + (row + mi) * PAD_W + col + ni) % (1 << VA_W));
            b.mm = 32'(row + mi);
            b.nn = 32'(col + ni);
            b.ch = 32'(c);
            sb.push_back(b);
          end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.wa = 32'(A_weight);
    b.va = 32'(A_Vmem);
    b.mm = 32'(current_M);
    b.nn = 32'(current_N);
    b.ch = 32'(current_ch);
    return b;
  endfunction

  // Called once per cycle, before the edge that would complete a transfer.
  task automatic observe();
    beat_t e, c;
    if (operating_flag) op_cycles++;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      c = cur_beat();
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("A_weight", c.wa, e.wa);
        chk("A_Vmem", c.va, e.va);
        chk("current_M", c.mm, e.mm);
        chk("current_N", c.nn, e.nn);
        chk("current_ch", c.ch, e.ch);
      end
      seen.push_back(c);
      xfers++;
    end
  endtask

  task automatic send_event(input int row, input int col);
    aer_event = {COORD_W'(row), COORD_W'(col)};
    aer_valid = 1'b1;
    tick();
    aer_valid = 1'b0;
    aer_event = 16'(($urandom() & 32'hFFFF));
  endtask

  task automatic run_sweep(input int stall_at, input int stall_len, input int budget);
    int cyc = 0;
    int stalled = 0;
    beat_t hold;
    while (done_cnt == 0 && cyc < budget) begin
      out_ready = 1'b1;
      if (xfers == stall_at && out_valid && stalled < stall_len) begin
        out_ready = 1'b0;
        if (stalled == 0) hold = cur_beat();
        stalled++;
      end
      if (stall_len > 0 && stalled > 1 && xfers == stall_at && out_valid) begin
        chk("hold_A_weight", 32'(A_weight), hold.wa);
        chk("hold_A_Vmem", 32'(A_Vmem), hold.va);
        chk("hold_current_N", 32'(current_N), hold.nn);
      end
      observe();
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
    chk("after_end_operating_flag", 32'(operating_flag), 32'd0);
    chk("after_end_aer_ready", 32'(aer_ready), 32'd1);
    chk("after_end_done", 32'(done), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int cyc, done1_cyc, acc_cyc, acc_op;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_aer_ready", 32'(aer_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_operating_flag", 32'(operating_flag), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_A_Vmem", 32'(A_Vmem), 32'd0);

    // Reset mid-sweep while beat 10 is on the outputs
    clr();
    push_event(3, 4);
    send_event(3, 4);
    cyc = 0;
    while (xfers < 9 && cyc < 100) begin
      observe();
      tick();
      cyc++;
    end
    chk("midsweep_beat10_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_operating_flag", 32'(operating_flag), 32'd0);
    chk("midrst_aer_ready", 32'(aer_ready), 32'd1);
    sb.delete();
    clr();
    for (int i = 0; i < 5; i++) begin
      observe();
      tick();
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);

    // Basic sweep, starts again from beat 0
    clr();
    push_event(3, 4);
    send_event(3, 4);
    run_sweep(-1, 0, 200);
    chk("basic_transfers", 32'(xfers), 32'd50);
    chk("basic_op_cycles", 32'(op_cycles), 32'd51);
    if (seen.size() >= 50) begin
      chk("beat1_A_weight", seen[0].wa, 32'd24);
      chk("beat1_A_Vmem", seen[0].va, 32'd100);
      chk("beat1_M", seen[0].mm, 32'd3);
      chk("beat1_N", seen[0].nn, 32'd4);
      chk("beat5_A_weight", seen[4].wa, 32'd20);
      chk("beat5_A_Vmem", seen[4].va, 32'd104);
      chk("beat6_A_weight", seen[5].wa, 32'd19);
      chk("beat6_A_Vmem", seen[5].va, 32'd132);
      chk("beat6_M", seen[5].mm, 32'd4);
      chk("beat25_A_weight", seen[24].wa, 32'd0);
      chk("beat25_A_Vmem", seen[24].va, 32'd232);
      chk("beat26_ch", seen[25].ch, 32'd1);
      chk("beat26_A_weight", seen[25].wa, 32'd49);
      chk("beat26_A_Vmem", seen[25].va, 32'd1124);
      chk("beat50_A_weight", seen[49].wa, 32'd25);
      chk("beat50_A_Vmem", seen[49].va, 32'd1256);
    end

    // Backpressure: 3 stall cycles while beat 7 is presented
    clr();
    push_event(3, 4);
    send_event(3, 4);
    run_sweep(6, 3, 200);
    chk("bp_transfers", 32'(xfers), 32'd50);
    chk("bp_op_cycles", 32'(op_cycles), 32'd54);

    // Clipping at the bottom-right corner
    clr();
    push_event(30, 30);
    send_event(30, 30);
    run_sweep(-1, 0, 200);
    chk("clip_transfers", 32'(xfers), 32'd8);
    chk("clip_op_cycles", 32'(op_cycles), 32'd51);
    if (seen.size() >= 8) begin
      chk("clip_ch0_first_A_Vmem", seen[0].va, 32'd990);
      chk("clip_ch1_first_A_Vmem", seen[4].va, 32'd2014);
      chk("clip_ch1_first_ch", seen[4].ch, 32'd1);
    end

    // Out-of-range event is dropped with an err pulse
    clr();
    send_event(32, 0);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_out_valid", 32'(out_valid), 32'd0);
    chk("oor_operating_flag", 32'(operating_flag), 32'd0);
    chk("oor_aer_ready", 32'(aer_ready), 32'd1);
    tick();
    chk("oor_err_pulse_end", 32'(err), 32'd0);
    chk("oor_still_idle", 32'(operating_flag), 32'd0);

    // Back-to-back events with aer_valid held; aer_event changes mid-sweep
    clr();
    push_event(3, 4);
    push_event(10, 20);
    aer_event = {8'd3, 8'd4};
    aer_valid = 1'b1;
    tick();
    aer_event = {8'd10, 8'd20};
    cyc = 0;
    done1_cyc = -1;
    acc_cyc = -1;
    acc_op = -1;
    while (done_cnt < 2 && cyc < 400) begin
      observe();
      if (done_cnt == 1 && done1_cyc < 0) done1_cyc = cyc;
      if (aer_valid && aer_ready && acc_cyc < 0) begin
        acc_cyc = cyc;
        acc_op = int'(operating_flag);
      end
      tick();
      if (acc_cyc >= 0) aer_valid = 1'b0;
      cyc++;
    end
    aer_valid = 1'b0;
    chk("b2b_done_pulses", 32'(done_cnt), 32'd2);
    chk("b2b_accept_after_end", 32'(acc_cyc), 32'(done1_cyc + 1));
    chk("b2b_gap_operating_flag", 32'(acc_op), 32'd0);
    chk("b2b_transfers", 32'(xfers), 32'd100);
    chk("b2b_op_cycles", 32'(op_cycles), 32'd102);
    chk("b2b_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
